// File: rtl/mod_exp_pkg.sv
// Shared types and default sizes for the Montgomery modular-exponentiation controller.
// The state encoding is shared by the controller and any debug or trace logic.
package mod_exp_pkg;

    localparam int DEF_DATA_W = 1024;
    localparam int DEF_EXP_W  = 1024;
    localparam int DEF_LEN_W  = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SQR_GO   = 3'd1,
        SQR_WAIT = 3'd2,
        MUL_GO   = 3'd3,
        MUL_WAIT = 3'd4,
        FIN_GO   = 3'd5,
        FIN_WAIT = 3'd6,
        DONE     = 3'd7
    } state_e;

    // Clamp a requested scan length to the exponent register width.
    function automatic logic [31:0] sat_len(input logic [31:0] len, input logic [31:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/exp_bit_iter.sv
// Exponent bit iterator: holds the captured exponent and walks a bit index from MSB-of-scan
// down to zero, exposing the currently selected bit and a last-bit flag.
module exp_bit_iter #(
    parameter int EXP_W = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             dec_i,
    output logic             bit_o,
    output logic             last_o
);

    logic [EXP_W-1:0] exp_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            exp_q <= exp_i;
            idx_q <= idx_i;
        end else if (dec_i) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    assign bit_o  = exp_q[idx_q];
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier;
// the final multiply by 1 converts the accumulator back out of the Montgomery domain.
//
// state    | meaning
// IDLE     | waiting for start; captures operands on acceptance
// SQR_GO   | issue acc*acc
// SQR_WAIT | wait for square result
// MUL_GO   | issue acc*x_tilde (current exponent bit is 1)
// MUL_WAIT | wait for multiply result
// FIN_GO   | issue acc*1 to leave Montgomery domain
// FIN_WAIT | wait for final result
// DONE     | one-cycle done pulse
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] x_tilde,
    input  logic [DATA_W-1:0] a_init,
    input  logic [EXP_W-1:0]  exp,
    input  logic [LEN_W-1:0]  exp_len,
    input  logic [DATA_W-1:0] modulus,
    output logic              mm_start,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    output logic [DATA_W-1:0] mm_m,
    input  logic [DATA_W-1:0] mm_result,
    input  logic              mm_done,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] n_q;

    logic [31:0]       len_sat;
    logic [IDX_W-1:0]  load_idx;
    logic              accept;
    logic              it_load;
    logic              it_dec;
    logic              it_bit;
    logic              it_last;

    assign len_sat  = sat_len(32'(exp_len), 32'(EXP_W));
    // A zero length wraps here, but the iterator is then never consulted.
    assign load_idx = IDX_W'(len_sat - 32'd1);
    assign accept   = (state_q == IDLE) && start;

    exp_bit_iter #(
        .EXP_W (EXP_W),
        .IDX_W (IDX_W)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load_i (it_load),
        .exp_i  (exp),
        .idx_i  (load_idx),
        .dec_i  (it_dec),
        .bit_o  (it_bit),
        .last_o (it_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            x_q      <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            if (accept) begin
                x_q <= x_tilde;
                n_q <= modulus;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        it_load  = 1'b0;
        it_dec   = 1'b0;
        mm_start = 1'b0;
        mm_a     = acc_q;
        mm_b     = acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    it_load = 1'b1;
                    acc_d   = a_init;
                    state_d = (len_sat == 32'd0) ? FIN_GO : SQR_GO;
                end
            end
            SQR_GO: begin
                mm_start = 1'b1;
                state_d  = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (it_bit) begin
                        state_d = MUL_GO;
                    end else if (it_last) begin
                        state_d = FIN_GO;
                    end else begin
                        it_dec  = 1'b1;
                        state_d = SQR_GO;
                    end
                end
            end
            MUL_GO: begin
                mm_start = 1'b1;
                mm_b     = x_q;
                state_d  = MUL_WAIT;
            end
            MUL_WAIT: begin
                mm_b = x_q;
                if (mm_done) begin
                    acc_d = mm_result;
                    if (it_last) begin
                        state_d = FIN_GO;
                    end else begin
                        it_dec  = 1'b1;
                        state_d = SQR_GO;
                    end
                end
            end
            FIN_GO: begin
                mm_start = 1'b1;
                mm_b     = DATA_W'(1);
                state_d  = FIN_WAIT;
            end
            FIN_WAIT: begin
                mm_b = DATA_W'(1);
                if (mm_done) begin
                    result_d = mm_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mm_m   = n_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural 16-bit Montgomery multiplier
// (a*b*2^-16 mod N, fixed five-cycle latency).
module tb_mod_exp_ctrl;

    localparam int DW = 16;
    localparam int EW = 32;
    localparam int LW = 11;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] m;
    } mm_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] x_tilde, a_init, modulus;
    logic [EW-1:0] exp_v;
    logic [LW-1:0] exp_len;
    logic          mm_start;
    logic [DW-1:0] mm_a, mm_b, mm_m;
    logic [DW-1:0] mm_result;
    logic          mm_done;
    logic          busy, done;
    logic [DW-1:0] result;

    int checks = 0;
    int errors = 0;
    int mm_pulses = 0;
    int done_cnt = 0;

    mm_t           exp_mm_q[$];
    logic [DW-1:0] exp_res_q[$];

    mod_exp_ctrl #(.DATA_W(DW), .EXP_W(EW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_tilde   (x_tilde),
        .a_init    (a_init),
        .exp       (exp_v),
        .exp_len   (exp_len),
        .modulus   (modulus),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic longint mont(input longint a, input longint b, input longint n);
        longint t;
        t = a * b;
        for (int i = 0; i < DW; i++) begin
            if (t[0]) t = t + n;
            t = t >>> 1;
        end
        if (t >= n) t = t - n;
        return t;
    endfunction

    function automatic longint golden(input longint x, input longint e, input longint n, input int lsat);
        longint r;
        r = 1;
        for (int i = lsat - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (((e >> i) & 1) != 0) r = (r * x) % n;
        end
        return r % n;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Behavioural multiplier; deliberately not reset so an in-flight result can arrive late.
    initial begin
        int     pend;
        longint pres;
        pend = 0;
        pres = 0;
        mm_done = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mm_done = 1'b1;
                    mm_result = DW'(pres);
                end
            end
            if (mm_start && !reset) begin
                pres = mont(longint'(mm_a), longint'(mm_b), longint'(mm_m));
                pend = 5;
            end
        end
    end

    // Monitor: pops expected operands on every mm_start and expected result on every done.
    always @(negedge clk) begin
        mm_t           e;
        logic [DW-1:0] r;
        if (!reset) begin
            if (mm_start) begin
                mm_pulses++;
                checks++;
                if (exp_mm_q.size() == 0) begin
                    errors++;
                    $display("FAIL mm_unexpected a=%0d b=%0d", mm_a, mm_b);
                end else begin
                    e = exp_mm_q.pop_front();
                    if (mm_a != e.a || mm_b != e.b || mm_m != e.m) begin
                        errors++;
                        $display("FAIL mm_operands got a=%0d b=%0d m=%0d expected a=%0d b=%0d m=%0d",
                                 mm_a, mm_b, mm_m, e.a, e.b, e.m);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected result=%0d", result);
                end else begin
                    r = exp_res_q.pop_front();
                    if (result != r) begin
                        errors++;
                        $display("FAIL result got=%0d expected=%0d", result, r);
                    end
                end
            end
        end
    end

    task automatic run_op(input string tag, input longint n, input longint x, input longint e,
                          input int len, input longint want, input bit poke, input bit abort);
        longint xt, ai, acc;
        int     lsat, npulse, base_p, base_d, cycles, busy_low;
        bit     poked;
        xt = (x << DW) % n;
        ai = (longint'(1) << DW) % n;
        lsat = (len > EW) ? EW : len;
        acc = ai;
        npulse = 0;
        for (int i = lsat - 1; i >= 0; i--) begin
            exp_mm_q.push_back('{DW'(acc), DW'(acc), DW'(n)});
            acc = mont(acc, acc, n);
            npulse++;
            if (((e >> i) & 1) != 0) begin
                exp_mm_q.push_back('{DW'(acc), DW'(xt), DW'(n)});
                acc = mont(acc, xt, n);
                npulse++;
            end
        end
        exp_mm_q.push_back('{DW'(acc), DW'(1), DW'(n)});
        npulse++;
        exp_res_q.push_back(DW'(want));

        base_p = mm_pulses;
        base_d = done_cnt;
        @(posedge clk); #1;
        x_tilde = DW'(xt); a_init = DW'(ai); modulus = DW'(n);
        exp_v = EW'(e); exp_len = LW'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_tilde = 16'hBEEF; a_init = 16'h1234; modulus = 16'h0FFF;
        exp_v = 32'h5A5A_5A5A; exp_len = 11'd7;
        cycles = 0;
        busy_low = 0;
        poked = 1'b0;
        while (done_cnt == base_d && cycles < 3000) begin
            if (!busy) busy_low++;
            start = 1'b0;
            if (poke && !poked && mm_pulses == base_p + 1) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (abort && mm_pulses == base_p + 2) break;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;

        if (abort) begin
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            exp_mm_q.delete();
            exp_res_q.delete();
            check({tag, "_abort_busy"}, busy, 0);
            check({tag, "_abort_result"}, result, 0);
            repeat (10) @(posedge clk);
            #1;
            check({tag, "_abort_no_done"}, done_cnt - base_d, 0);
            check({tag, "_abort_no_mm"}, mm_pulses - base_p, 2);
            check({tag, "_abort_idle"}, busy, 0);
        end else begin
            check({tag, "_done_seen"}, done_cnt - base_d, 1);
            check({tag, "_busy_drop"}, busy, 0);
            check({tag, "_busy_held"}, busy_low, 0);
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_single_done"}, done_cnt - base_d, 1);
            check({tag, "_mm_count"}, mm_pulses - base_p, npulse);
            check({tag, "_result_hold"}, result, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_tilde = '0; a_init = '0; modulus = '0; exp_v = '0; exp_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_result", result, 0);
        reset = 1'b0;

        run_op("basic", 13, 2, 11, 4, 7, 1'b0, 1'b0);
        run_op("len0", 13, 5, 'hFFFF, 0, 1, 1'b0, 1'b0);
        run_op("e_zero", 13, 2, 0, 4, 1, 1'b0, 1'b0);
        run_op("restart", 13, 2, 11, 4, 7, 1'b1, 1'b0);
        run_op("abort", 13, 2, 11, 4, 7, 1'b0, 1'b1);
        run_op("after", 13, 3, 5, 3, 9, 1'b0, 1'b0);
        run_op("sat", 65521, 7, 'hDEADBEEF, 40, golden(7, 'hDEADBEEF, 65521, 32), 1'b0, 1'b0);

        check("queue_mm_empty", exp_mm_q.size(), 0);
        check("queue_res_empty", exp_res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 1024: operand/modulus width.
REQ-002 SHALL have parameter EXP_W, default 1024: exponent register width.
REQ-003 SHALL have parameter LEN_W, default 11: exponent-length field width.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request; accepted only in IDLE.
REQ-008 x_tilde  in  DATA_W  base already in Montgomery domain (X*R mod N).
REQ-009 a_init  in  DATA_W  R mod N (Montgomery one).
REQ-010 exp  in  EXP_W  exponent E, LSB = bit 0.
REQ-011 exp_len  in  LEN_W  number of exponent bits to scan.
REQ-012 modulus  in  DATA_W  N, odd.
REQ-013 mm_start  out  1  one-cycle start pulse to the Montgomery multiplier.
REQ-014 mm_a, mm_b, mm_m  out  DATA_W each  multiplier operands.
REQ-015 mm_result  in  DATA_W  multiplier result, valid with mm_done.
REQ-016 mm_done  in  1  multiplier completion pulse.
REQ-017 busy  out  1  high from start acceptance until done.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 result  out  DATA_W  X^E mod N in the normal domain, held until the next accepted start.

Function
REQ-020 SHALL capture x_tilde, a_init, exp, modulus and exp_len on the start-acceptance edge; later input changes SHALL have no effect.
REQ-021 SHALL saturate exp_len values greater than EXP_W to EXP_W.
REQ-022 SHALL use states IDLE, SQR_GO, SQR_WAIT, MUL_GO, MUL_WAIT, FIN_GO, FIN_WAIT, DONE.
REQ-023 IDLE: on start, SHALL load acc <= a_init and idx <= len-1, then go to SQR_GO; if len == 0, SHALL go to FIN_GO instead.
REQ-024 SQR_GO: SHALL assert mm_start for exactly one cycle with mm_a = mm_b = acc, then go to SQR_WAIT.
REQ-025 SQR_WAIT: on mm_done, SHALL set acc <= mm_result; if exp[idx] == 1, SHALL go to MUL_GO; otherwise SHALL go to step-next.
REQ-026 MUL_GO: SHALL pulse mm_start with mm_a = acc and mm_b = x_tilde, then go to MUL_WAIT; on mm_done, SHALL set acc <= mm_result and go to step-next.
REQ-027 Step-next: if idx == 0, SHALL go to FIN_GO; otherwise SHALL decrement idx and go to SQR_GO.
REQ-028 FIN_GO: SHALL pulse mm_start with mm_a = acc and mm_b = 1; in FIN_WAIT, on mm_done, SHALL set result <= mm_result and go to DONE.
REQ-029 DONE: SHALL assert done for one cycle, deassert busy on the following edge, and return to IDLE.
REQ-030 mm_m SHALL equal the captured modulus at all times after start acceptance.
REQ-031 mm_done outside a *_WAIT state SHALL be ignored.
REQ-032 start while busy SHALL be ignored.
REQ-033 Exactly len squares, popcount(exp[len-1:0]) multiplies and 1 final multiply SHALL be issued per operation; no mm_start SHALL be issued in any other state.
REQ-034 Latency: start to done = 2*len + 2*popcount + 3 cycles + the sum of all multiplier latencies.

Reset
REQ-035 Reset SHALL force IDLE; mm_start, busy and done = 0; result, acc and idx = 0.
REQ-036 Reset mid-operation SHALL abort with no done pulse; a pending mm_done SHALL be ignored after reset.

Structure
REQ-037 mod_exp_pkg SHALL hold the state enumeration and the default DATA_W/EXP_W/LEN_W constants.
REQ-038 The exponent bit index/selection logic is a natural sub-module exp_bit_iter (load, decrement, current bit, last flag).
REQ-039 The Montgomery multiplier SHALL remain external, connected only through the mm_* ports.

Verification
Bench uses a behavioural multiplier: result = a*b*R^-1 mod N, R = 2^DATA_W, fixed 5-cycle latency; DATA_W = 16.
REQ-040 N=13, X=2, E=11, len=4 -> 8 mm_start pulses (S,M,S,S,M,S,M,F), result = 7, one done pulse.
REQ-041 len=0, any E -> exactly 1 mm_start with mm_b = 1, result = 1.
REQ-042 E=0x0000, len=4 -> 4 squares and 0 multiplies, result = 1; busy high throughout the operation.
REQ-043 start re-asserted during SQR_WAIT -> ignored; mm_start count and result unchanged.
REQ-044 reset asserted in MUL_WAIT, then a stray mm_done -> IDLE, no done pulse; next run N=13, X=3, E=5, len=3 -> result = 9.
REQ-045 len=40 with EXP_W=32 -> saturated to 32 bits scanned; result matches the golden modexp.
